// File: rtl/proc_trace_pkg.sv
// ============================================================================
// Module      : proc_trace_pkg
// Description : Shared record type and widths for the processor trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_trace_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    localparam int TRACE_REC_W = 64;
    localparam int DROP_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/proc_trace_buf_mem.sv
// ============================================================================
// Module      : proc_trace_buf_mem
// Description : DEPTH-entry trace record storage, one synchronous write port
//               and one combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_trace_buf_mem
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  trace_rec_t    wdata,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/proc_trace_buffer.sv
// ============================================================================
// Module      : proc_trace_buffer
// Description : Trace-port capture FIFO with val/rdy drain and drop reporting.
//               Optional drop counter built when PROC_TRACE_BUF_DROP_CNT_EN
//               is defined; otherwise drop_count reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trace_val,
    input  logic [31:0]           trace_addr,
    input  logic [31:0]           trace_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [31:0]           out_addr,
    output logic [31:0]           out_data,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]   c_cnt_full = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    trace_rec_t    w_wr_rec;
    trace_rec_t    w_rd_rec;

    assign full     = (r_count == c_cnt_full);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign out_val  = !empty;

    // A full buffer still accepts a record when the head leaves in the same cycle.
    assign w_pop  = out_val & out_rdy;
    assign w_push = trace_val & (!full | w_pop);
    assign w_drop = trace_val & full & !w_pop;

    assign w_wr_rec.addr = trace_addr;
    assign w_wr_rec.data = trace_data;

    proc_trace_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .wen   (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wr_rec),
        .raddr (r_rd_ptr),
        .rdata (w_rd_rec)
    );

    assign out_addr = w_rd_rec.addr;
    assign out_data = w_rd_rec.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PROC_TRACE_BUF_DROP_CNT_EN
    localparam logic [DROP_CNT_W-1:0] c_drop_max = '1;
    localparam logic [DROP_CNT_W-1:0] c_drop_one = DROP_CNT_W'(1);

    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_drop_max)) begin
            r_drop_cnt <= r_drop_cnt + c_drop_one;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_trace_buffer.sv
// ============================================================================
// Module      : tb_proc_trace_buffer
// Description : Directed self-checking bench for proc_trace_buffer (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_trace_buffer;

`ifdef PROC_TRACE_BUF_DROP_CNT_EN
    localparam logic [15:0] c_exp_drop1 = 16'd1;
`else
    localparam logic [15:0] c_exp_drop1 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_count;

    int n_pass   = 0;
    int n_checks = 0;

    proc_trace_buffer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        trace_val  = 1'b1;
        trace_addr = a;
        trace_data = d;
        tick();
        trace_val  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        trace_val  = 1'b0;
        trace_addr = '0;
        trace_data = '0;
        out_rdy    = 1'b0;

        // Reset state, observed before any clock edge
        #2;
        check("rst_out_val",  64'(out_val),    64'd0);
        check("rst_empty",    64'(empty),      64'd1);
        check("rst_full",     64'(full),       64'd0);
        check("rst_count",    64'(count),      64'd0);
        check("rst_overflow", 64'(overflow),   64'd0);
        check("rst_drop",     64'(drop_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Three pushes then drain in order
        push(32'h200, 32'h11);
        push(32'h204, 32'h22);
        push(32'h208, 32'h33);
        check("t2_count", 64'(count),    64'd3);
        check("t2_head",  64'(out_addr), 64'h200);
        check("t2_data",  64'(out_data), 64'h11);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_order", 64'(out_addr), 64'(32'h200 + 32'(4 * i)));
            tick();
        end
        check("t2_empty",   64'(empty),   64'd1);
        check("t2_out_val", 64'(out_val), 64'd0);
        tick();
        check("t2_no_pop_empty", 64'(count), 64'd0);
        out_rdy = 1'b0;

        // Fill to DEPTH, then a dropped record
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(4 * i), 32'(i));
        end
        check("t3_full",  64'(full),  64'd1);
        check("t3_count", 64'(count), 64'd8);
        push(32'h300, 32'hAA);
        check("t3_count_drop", 64'(count),      64'd8);
        check("t3_head",       64'(out_addr),   64'h100);
        check("t3_head_data",  64'(out_data),   64'h0);
        check("t3_overflow",   64'(overflow),   64'd1);
        check("t3_drop_count", 64'(drop_count), 64'(c_exp_drop1));

        do_reset();
        check("t4_ovf_clear", 64'(overflow), 64'd0);

        // Full with simultaneous push and pop: no drop
        for (int i = 0; i < 8; i++) begin
            push(32'h600 + 32'(4 * i), 32'h60 + 32'(i));
        end
        check("t4_full", 64'(full), 64'd1);
        out_rdy = 1'b1;
        push(32'h400, 32'hBB);
        check("t4_count",    64'(count),      64'd8);
        check("t4_overflow", 64'(overflow),   64'd0);
        check("t4_drop",     64'(drop_count), 64'd0);
        for (int i = 1; i < 8; i++) begin
            check("t4_order", 64'(out_addr), 64'(32'h600 + 32'(4 * i)));
            tick();
        end
        check("t4_last_addr", 64'(out_addr), 64'h400);
        check("t4_last_data", 64'(out_data), 64'hBB);
        tick();
        check("t4_empty", 64'(empty), 64'd1);

        // Back-to-back stream with consumer always ready
        for (int k = 0; k < 20; k++) begin
            trace_val  = 1'b1;
            trace_addr = 32'h700 + 32'(4 * k);
            trace_data = 32'h7000 + 32'(k);
            if (k == 0) begin
                #1;
                check("t5_no_bypass", 64'(out_val), 64'd0);
            end
            tick();
            check("t5_head",  64'(out_addr), 64'(32'h700 + 32'(4 * k)));
            check("t5_count", 64'(count),    64'd1);
        end
        trace_val = 1'b0;
        tick();
        check("t5_drained",  64'(empty),    64'd1);
        check("t5_overflow", 64'(overflow), 64'd0);
        out_rdy = 1'b0;

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            push(32'h800 + 32'(4 * i), 32'(i));
        end
        check("t6_count5", 64'(count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_val",   64'(out_val), 64'd0);
        check("t6_async_count", 64'(count),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        push(32'h500, 32'h1);
        check("t6_first_addr", 64'(out_addr), 64'h500);
        check("t6_first_data", 64'(out_data), 64'h1);
        check("t6_count",      64'(count),    64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
